// File: rtl/rm_dispatcher.sv
// Raymarcher work dispatcher: issues raster-order pixels to free cores and
// collects finished colours round-robin into one framebuffer write register.
module rm_dispatcher #(
   parameter int NCORES = 4,
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int CORDW  = 10,
   parameter int ADDRW  = 19
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frame_start,
   output logic                 busy,
   output logic                 frame_done,
   output logic [NCORES-1:0]    core_start,
   output logic [CORDW-1:0]     core_x,
   output logic [CORDW-1:0]     core_y,
   input  logic [NCORES-1:0]    core_done,
   input  logic [NCORES*24-1:0] core_rgb,
   output logic [NCORES-1:0]    core_ack,
   output logic                 fb_we,
   output logic [ADDRW-1:0]     fb_addr,
   output logic [23:0]          fb_data,
   input  logic                 fb_ready
);

   localparam int PTRW = (NCORES > 1) ? $clog2(NCORES) : 1;

   typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} state_t;

   state_t            state, state_next;
   logic [CORDW-1:0]  x, y;
   logic [ADDRW-1:0]  addr;
   logic [NCORES-1:0] inflight;
   logic [ADDRW-1:0]  addr_slot [NCORES];
   logic [PTRW-1:0]   rr_ptr;

   logic              issue;
   logic [NCORES-1:0] issue_onehot;
   logic              last_pixel;

   logic              load_en;
   logic              grant;
   logic [PTRW-1:0]   grant_idx;
   logic [NCORES-1:0] grant_onehot;
   logic [ADDRW-1:0]  wb_addr;
   logic [23:0]       wb_data;

   assign last_pixel = (x == CORDW'(H_RES - 1)) && (y == CORDW'(V_RES - 1));

   // Lowest-index core whose inflight bit is clear; a bit cleared by this
   // cycle's ack is still set here, so that core waits one cycle.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      issue        = 1'b0;
      issue_onehot = '0;
      if (state == DISPATCH) begin
         for (int i = 0; i < NCORES; i++) begin
            if (!issue && !inflight[i]) begin
               issue           = 1'b1;
               issue_onehot[i] = 1'b1;
            end
         end
      end
   end

   // Round-robin result pick: first search above the last-served core, then wrap.
   always_comb begin
      load_en      = !fb_we || fb_ready;
      grant        = 1'b0;
      grant_idx    = '0;
      grant_onehot = '0;
      wb_addr      = '0;
      wb_data      = '0;
      if (load_en) begin
         for (int i = 0; i < NCORES; i++) begin
            if (!grant && core_done[i] && inflight[i] && i > int'(rr_ptr)) begin
               grant           = 1'b1;
               grant_idx       = PTRW'(i);
               grant_onehot[i] = 1'b1;
               wb_addr         = addr_slot[i];
               wb_data         = core_rgb[24*i +: 24];
            end
         end
         for (int i = 0; i < NCORES; i++) begin
            if (!grant && core_done[i] && inflight[i] && i <= int'(rr_ptr)) begin
               grant           = 1'b1;
               grant_idx       = PTRW'(i);
               grant_onehot[i] = 1'b1;
               wb_addr         = addr_slot[i];
               wb_data         = core_rgb[24*i +: 24];
            end
         end
      end
   end

   assign core_ack = grant_onehot;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (frame_start) state_next = DISPATCH;
         DISPATCH: if (issue && last_pixel) state_next = DRAIN;
         DRAIN:    if (inflight == '0 && !fb_we) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         core_start <= '0;
         core_x     <= '0;
         core_y     <= '0;
         x          <= '0;
         y          <= '0;
         addr       <= '0;
         inflight   <= '0;
         rr_ptr     <= PTRW'(NCORES - 1);
         fb_we      <= 1'b0;
         fb_addr    <= '0;
         fb_data    <= '0;
      end else begin
         state      <= state_next;
         busy       <= (state_next != IDLE);
         frame_done <= (state == DRAIN) && (state_next == IDLE);
         core_start <= issue_onehot;
         if (issue) begin
            core_x <= x;
            core_y <= y;
         end

         if (state == IDLE && frame_start) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
         end else if (issue) begin
            addr <= addr + ADDRW'(1);
            if (x == CORDW'(H_RES - 1)) begin
               x <= '0;
               y <= y + CORDW'(1);
            end else begin
               x <= x + CORDW'(1);
            end
         end

         inflight <= (inflight | issue_onehot) & ~grant_onehot;

         if (load_en) begin
            fb_we <= grant;
            if (grant) begin
               fb_addr <= wb_addr;
               fb_data <= wb_data;
            end
         end
         if (grant) rr_ptr <= grant_idx;
      end
   end

   // NOTE: address slots are plain storage qualified by inflight, so they carry no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NCORES; i++) begin
         if (issue_onehot[i]) addr_slot[i] <= addr;
      end
   end

endmodule

// File: tb/tb_rm_dispatcher.sv
// Scoreboard bench for rm_dispatcher: behavioural cores, expected writes queued
// at frame start, and a monitor that retires them as the framebuffer accepts.
module tb_rm_dispatcher;

   localparam int NCORES = 4;
   localparam int H_RES  = 6;
   localparam int V_RES  = 4;
   localparam int CORDW  = 4;
   localparam int ADDRW  = 5;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 frame_start;
   logic                 busy;
   logic                 frame_done;
   logic [NCORES-1:0]    core_start;
   logic [CORDW-1:0]     core_x;
   logic [CORDW-1:0]     core_y;
   logic [NCORES-1:0]    core_done = '0;
   logic [NCORES*24-1:0] core_rgb  = '0;
   logic [NCORES-1:0]    core_ack;
   logic                 fb_we;
   logic [ADDRW-1:0]     fb_addr;
   logic [23:0]          fb_data;
   logic                 fb_ready;

   always #10 clk = ~clk;

   rm_dispatcher #(
      .NCORES(NCORES), .H_RES(H_RES), .V_RES(V_RES), .CORDW(CORDW), .ADDRW(ADDRW)
   ) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .busy(busy),
      .frame_done(frame_done), .core_start(core_start), .core_x(core_x),
      .core_y(core_y), .core_done(core_done), .core_rgb(core_rgb),
      .core_ack(core_ack), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
      .fb_ready(fb_ready)
   );

   typedef struct packed {
      logic [ADDRW-1:0] addr;
      logic [23:0]      data;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  fails  = 0;
   bit  in_order = 1'b0;
   bit  rand_ready = 1'b0;
   bit  rr_mode = 1'b0, rr_seen = 1'b0, rr_next = 1'b0;
   int  done_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [23:0] colour(input int px, input int py);
      logic [7:0] r, g, b;
      r = 8'((px * 37 + 11) & 255);
      g = 8'((py * 53 + 7) & 255);
      b = 8'((px * py + px + 200) & 255);
      return {r, g, b};
   endfunction

   // Behavioural cores: result appears lat cycles after the start is seen,
   // held until acked.
   int   lat [NCORES];
   int   cnt [NCORES];
   int   px  [NCORES];
   int   py  [NCORES];
   logic [NCORES-1:0] core_busy = '0;

   always @(posedge clk) begin
      for (int i = 0; i < NCORES; i++) begin
         if (rst) begin
            core_done[i] <= 1'b0;
            core_busy[i] <= 1'b0;
            cnt[i]       <= 0;
         end else begin
            if (core_ack[i]) begin
               core_done[i] <= 1'b0;
               core_busy[i] <= 1'b0;
            end
            if (core_start[i]) begin
               cnt[i]       <= lat[i];
               px[i]        <= int'(core_x);
               py[i]        <= int'(core_y);
               core_busy[i] <= 1'b1;
            end else if (cnt[i] != 0) begin
               cnt[i] <= cnt[i] - 1;
               if (cnt[i] == 1) begin
                  core_done[i]         <= 1'b1;
                  core_rgb[24*i +: 24] <= colour(px[i], py[i]);
               end
            end
         end
      end
   end

   wr_t got;
   int  idx;

   always @(negedge clk) begin
      #1;
      if (!rst) begin
         if (fb_we && fb_ready) begin
            got = {fb_addr, fb_data};
            check("write expected by scoreboard", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               if (in_order) begin
                  check("raster-order write", got, exp_q[0]);
                  void'(exp_q.pop_front());
               end else begin
                  idx = -1;
                  foreach (exp_q[j]) if (exp_q[j].addr == fb_addr) idx = j;
                  check("write address pending", idx >= 0, 1);
                  if (idx >= 0) begin
                     check("write colour", fb_data, exp_q[idx].data);
                     exp_q.delete(idx);
                  end
               end
            end
         end
         if (core_start != '0) begin
            check("core_start one-hot", $onehot(core_start), 1);
            check("core_start to inflight core", (core_start & core_busy) != '0, 0);
         end
         if (core_ack != '0) begin
            check("core_ack one-hot", $onehot(core_ack), 1);
            check("ack without done", (core_ack & ~core_done) != '0, 0);
            check("ack while write stalled", fb_we && !fb_ready, 0);
         end
         if (rr_next) begin
            check("round-robin second ack", core_ack, 4'b0100);
            rr_next = 1'b0;
         end else if (rr_mode && !rr_seen && core_ack == 4'b0001) begin
            rr_seen = 1'b1;
            rr_next = 1'b1;
            check("core 2 done alongside core 0", core_done[2], 1);
         end
         if (frame_done) begin
            done_cnt++;
            check("all pixels written at frame_done", exp_q.size(), 0);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, " busy"}, busy, 0);
      check({tag, " frame_done"}, frame_done, 0);
      check({tag, " core_start"}, core_start, 0);
      check({tag, " core_ack"}, core_ack, 0);
      check({tag, " fb_we"}, fb_we, 0);
      check({tag, " core_x"}, core_x, 0);
      check({tag, " core_y"}, core_y, 0);
      check({tag, " fb_addr"}, fb_addr, 0);
      check({tag, " fb_data"}, fb_data, 0);
   endtask

   task automatic push_frame();
      for (int yy = 0; yy < V_RES; yy++)
         for (int xx = 0; xx < H_RES; xx++)
            exp_q.push_back({ADDRW'(yy * H_RES + xx), colour(xx, yy)});
   endtask

   task automatic start_frame();
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      check("busy after frame_start", busy, 1);
      check("no issue in request cycle", core_start, 0);
      @(negedge clk);
      check("first issue to core 0", core_start, 4'b0001);
      check("first issue x", core_x, 0);
      check("first issue y", core_y, 0);
   endtask

   task automatic wait_done(input int max_cycles);
      int n = 0;
      while (done_cnt == 0 && n < max_cycles) begin
         @(negedge clk);
         if (rand_ready) fb_ready = 1'($urandom_range(0, 1));
         n++;
      end
      check("frame_done within budget", done_cnt != 0, 1);
      fb_ready = 1'b1;
      repeat (5) @(negedge clk);
      check("exactly one frame_done", done_cnt, 1);
      check("idle after frame", busy, 0);
      done_cnt = 0;
   endtask

   task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
      lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
   endtask

   bit snap_we;
   logic [ADDRW-1:0] snap_addr;
   logic [23:0] snap_data;
   bit stable_ok;
   bit late_start;

   initial begin
      rst = 1'b1;
      frame_start = 1'b0;
      fb_ready = 1'b1;
      set_lat(3, 3, 3, 3);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset_outputs("reset");

      // Equal latencies, always ready: writes in raster order; extra request ignored.
      in_order = 1'b1;
      push_frame();
      start_frame();
      repeat (3) @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      wait_done(2000);
      repeat (10) @(negedge clk);
      check("ignored request gives no frame_done", done_cnt, 0);
      check("ignored request leaves idle", busy, 0);

      // Core 3 fast, cores 0 and 2 finish together while the pointer sits at 3.
      in_order = 1'b0;
      set_lat(10, 30, 8, 1);
      rr_mode = 1'b1;
      push_frame();
      start_frame();
      wait_done(3000);
      rr_mode = 1'b0;
      check("round-robin scenario reached", rr_seen, 1);

      // Framebuffer back-pressure for 50 cycles mid-frame.
      set_lat(2, 2, 2, 2);
      push_frame();
      start_frame();
      repeat (6) @(negedge clk);
      fb_ready = 1'b0;
      for (int i = 0; i < 10 && !fb_we; i++) @(negedge clk);
      check("write pending at stall", fb_we, 1);
      snap_we = fb_we; snap_addr = fb_addr; snap_data = fb_data;
      stable_ok = 1'b1;
      late_start = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (fb_we != snap_we || fb_addr != snap_addr || fb_data != snap_data) stable_ok = 1'b0;
         if (i >= 10 && core_start != '0) late_start = 1'b1;
      end
      check("fb outputs held during stall", stable_ok, 1);
      check("dispatch stalled with all cores inflight", late_start, 0);
      check("frame still busy during stall", busy, 1);
      fb_ready = 1'b1;
      wait_done(3000);

      // Uneven latencies with random back-pressure.
      set_lat(5, 1, 12, 3);
      rand_ready = 1'b1;
      push_frame();
      start_frame();
      wait_done(4000);
      rand_ready = 1'b0;

      // Reset mid-frame, then a fresh frame from the origin.
      in_order = 1'b1;
      set_lat(3, 3, 3, 3);
      push_frame();
      start_frame();
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_outputs("mid-frame reset");
      exp_q.delete();
      done_cnt = 0;
      @(negedge clk);
      push_frame();
      start_frame();
      wait_done(2000);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
